// File: rtl/rx_block_lock_multi.sv
// -----------------------------------------------------------------------------
// rx_block_lock_multi
//   Per-lane 64b/66b block-lock engine. Each lane hunts for sync-header
//   alignment by pulsing the gearbox slip request, declares lock after
//   P_LOCK_CNT consecutive good headers, and drops lock when P_BAD_MAX bad
//   headers arrive within one P_WINDOW-header window. Lanes are independent;
//   a disabled lane is held in its reset state but keeps its slip statistics.
//
// Ports
//   clk_i            RX user clock
//   rst_i            synchronous reset, active-high
//   lane_en_i        per-lane enable (0 holds the lane in reset, slip count kept)
//   rxheader_i       sync header, lane n at [2n+1:2n]
//   rxheadervalid_i  header strobe, lane n at [n]
//   rxgearboxslip_o  one-cycle slip request to the gearbox, per lane
//   locked_o         per-lane block lock
//   all_locked_o     AND of locked_o over enabled lanes, 0 if none enabled
//   slip_cnt_o       saturating 8-bit slip count, lane n at [8n+7:8n]
// -----------------------------------------------------------------------------
module rx_block_lock_multi #(
  parameter int unsigned P_LANES          = 1,
  parameter int unsigned P_SLIP_GAP_WIDTH = 8,
  parameter int unsigned P_LOCK_CNT       = 64,
  parameter int unsigned P_WINDOW         = 64,
  parameter int unsigned P_BAD_MAX        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [P_LANES-1:0]     lane_en_i,
  input  logic [2*P_LANES-1:0]   rxheader_i,
  input  logic [P_LANES-1:0]     rxheadervalid_i,
  output logic [P_LANES-1:0]     rxgearboxslip_o,
  output logic [P_LANES-1:0]     locked_o,
  output logic                   all_locked_o,
  output logic [8*P_LANES-1:0]   slip_cnt_o
);

  localparam int unsigned GW = $clog2(P_LOCK_CNT + 1);
  localparam int unsigned HW = $clog2(P_WINDOW + 1);
  localparam int unsigned BW = $clog2(P_BAD_MAX + 1);

  // Compare against "last value before threshold" so counters never need to
  // hold the threshold itself.
  localparam logic [GW-1:0] GOOD_LAST = GW'(P_LOCK_CNT - 1);
  localparam logic [HW-1:0] WIN_LAST  = HW'(P_WINDOW - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(P_BAD_MAX - 1);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } lane_state_e;

  for (genvar n = 0; n < P_LANES; n++) begin : g_lane
    lane_state_e                 state_q;
    logic [GW-1:0]               good_cnt_q;
    logic [HW-1:0]               hdr_cnt_q;
    logic [BW-1:0]               bad_cnt_q;
    logic [P_SLIP_GAP_WIDTH-1:0] wait_cnt_q;
    logic [7:0]                  slip_cnt_q;
    logic [7:0]                  slip_cnt_d;
    logic                        slip_q;
    logic                        locked_q;
    logic [1:0]                  hdr;
    logic                        hdr_vld;
    logic                        hdr_good;

    assign hdr        = rxheader_i[2*n +: 2];
    assign hdr_vld    = rxheadervalid_i[n];
    assign hdr_good   = hdr[1] ^ hdr[0];
    assign slip_cnt_d = (&slip_cnt_q) ? slip_cnt_q : slip_cnt_q + 8'd1;

    always_ff @(posedge clk_i) begin
      if (rst_i || !lane_en_i[n]) begin
        // NOTE: synchronous reset lives inside the clocked block; every
        // register gets a reset value here, no reset-less state remains.
        state_q    <= ST_HUNT;
        good_cnt_q <= '0;
        hdr_cnt_q  <= '0;
        bad_cnt_q  <= '0;
        wait_cnt_q <= '0;
        slip_q     <= 1'b0;
        locked_q   <= 1'b0;
        if (rst_i) slip_cnt_q <= '0;
      end else begin
        // NOTE: non-blocking default then conditional override; the last
        // scheduled assignment wins, so the slip request is a single cycle.
        slip_q <= 1'b0;
        unique case (state_q)
          ST_HUNT: begin
            if (hdr_vld) begin
              if (hdr_good) begin
                if (good_cnt_q == GOOD_LAST) begin
                  state_q    <= ST_LOCKED;
                  locked_q   <= 1'b1;
                  good_cnt_q <= '0;
                  hdr_cnt_q  <= '0;
                  bad_cnt_q  <= '0;
                end else begin
                  good_cnt_q <= good_cnt_q + GW'(1);
                end
              end else begin
                state_q    <= ST_SLIP_WAIT;
                good_cnt_q <= '0;
                slip_q     <= 1'b1;
                slip_cnt_q <= slip_cnt_d;
                wait_cnt_q <= '0;
              end
            end
          end
          ST_SLIP_WAIT: begin
            // Counter starts at 0 on the slip-pulse cycle and wraps back to 0
            // on the exit cycle, giving exactly 2**P_SLIP_GAP_WIDTH cycles.
            wait_cnt_q <= wait_cnt_q + P_SLIP_GAP_WIDTH'(1);
            if (&wait_cnt_q) begin
              state_q    <= ST_HUNT;
              good_cnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (hdr_vld) begin
              // Unlock is tested first so it wins over a coincident window end.
              if (!hdr_good && (bad_cnt_q == BAD_LAST)) begin
                state_q    <= ST_SLIP_WAIT;
                locked_q   <= 1'b0;
                slip_q     <= 1'b1;
                slip_cnt_q <= slip_cnt_d;
                wait_cnt_q <= '0;
                hdr_cnt_q  <= '0;
                bad_cnt_q  <= '0;
              end else if (hdr_cnt_q == WIN_LAST) begin
                hdr_cnt_q <= '0;
                bad_cnt_q <= '0;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + HW'(1);
                if (!hdr_good) bad_cnt_q <= bad_cnt_q + BW'(1);
              end
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end

    assign rxgearboxslip_o[n]    = slip_q;
    assign locked_o[n]           = locked_q;
    assign slip_cnt_o[8*n +: 8]  = slip_cnt_q;
  end

  logic all_locked_q;

  // Built from the registered lock flags, so it trails locked_o by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) all_locked_q <= 1'b0;
    else       all_locked_q <= (|lane_en_i) && (&(locked_o | ~lane_en_i));
  end

  assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_rx_block_lock_multi.sv
module tb_rx_block_lock_multi;

  localparam int LANES = 4;
  localparam int GAPW  = 4;
  localparam int WAIT  = 1 << GAPW;
  localparam int LOCK  = 64;
  localparam int WIN   = 64;
  localparam int BAD   = 16;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [LANES-1:0]     lane_en_i;
  logic [2*LANES-1:0]   rxheader_i;
  logic [LANES-1:0]     rxheadervalid_i;
  logic [LANES-1:0]     rxgearboxslip_o;
  logic [LANES-1:0]     locked_o;
  logic                 all_locked_o;
  logic [8*LANES-1:0]   slip_cnt_o;

  rx_block_lock_multi #(
    .P_LANES(LANES), .P_SLIP_GAP_WIDTH(GAPW), .P_LOCK_CNT(LOCK),
    .P_WINDOW(WIN), .P_BAD_MAX(BAD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .lane_en_i(lane_en_i), .rxheader_i(rxheader_i),
    .rxheadervalid_i(rxheadervalid_i), .rxgearboxslip_o(rxgearboxslip_o),
    .locked_o(locked_o), .all_locked_o(all_locked_o), .slip_cnt_o(slip_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Behavioural reference: per-lane flags and plain integer counters.
  bit [LANES-1:0] m_locked = '0;
  bit [LANES-1:0] m_slip   = '0;
  bit             m_all    = 1'b0;
  int m_wait [LANES];
  int m_good [LANES];
  int m_hdrs [LANES];
  int m_bads [LANES];
  int m_slips[LANES];
  int last_slip[LANES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic take_slip(input int n);
    m_slip[n]  = 1'b1;
    m_slips[n] = (m_slips[n] >= 255) ? 255 : m_slips[n] + 1;
    m_wait[n]  = WAIT;
    m_good[n]  = 0;
    m_hdrs[n]  = 0;
    m_bads[n]  = 0;
  endtask

  task automatic model_step(input bit rst, input bit [LANES-1:0] en,
                            input bit [2*LANES-1:0] hdr, input bit [LANES-1:0] hv);
    bit [LANES-1:0] prev;
    prev  = m_locked;
    m_all = !rst && (en != '0) && ((prev | ~en) == '1);
    for (int n = 0; n < LANES; n++) begin
      bit [1:0] h;
      bit good;
      h    = hdr[2*n +: 2];
      good = (h == 2'b01) || (h == 2'b10);
      m_slip[n] = 1'b0;
      if (rst || !en[n]) begin
        m_locked[n] = 1'b0;
        m_wait[n] = 0; m_good[n] = 0; m_hdrs[n] = 0; m_bads[n] = 0;
        if (rst) m_slips[n] = 0;
      end else if (m_wait[n] > 0) begin
        m_wait[n]--;
      end else if (hv[n]) begin
        if (m_locked[n]) begin
          m_hdrs[n]++;
          if (!good) m_bads[n]++;
          if (m_bads[n] >= BAD) begin
            m_locked[n] = 1'b0;
            take_slip(n);
          end else if (m_hdrs[n] >= WIN) begin
            m_hdrs[n] = 0;
            m_bads[n] = 0;
          end
        end else if (good) begin
          m_good[n]++;
          if (m_good[n] >= LOCK) begin
            m_locked[n] = 1'b1;
            m_good[n] = 0; m_hdrs[n] = 0; m_bads[n] = 0;
          end
        end else begin
          take_slip(n);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [8*LANES-1:0] exp_cnt;
    for (int n = 0; n < LANES; n++) exp_cnt[8*n +: 8] = 8'(m_slips[n]);
    check("slip", rxgearboxslip_o, m_slip);
    check("locked", locked_o, m_locked);
    check("all_locked", all_locked_o, m_all);
    check("slip_cnt", slip_cnt_o, exp_cnt);
    for (int n = 0; n < LANES; n++) begin
      if (rxgearboxslip_o[n] === 1'b1) begin
        check("slip_gap", ((cyc - last_slip[n]) >= WAIT), 1'b1);
        last_slip[n] = cyc;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, compare on the falling edge.
  task automatic cycle(input bit rst, input bit [LANES-1:0] en,
                       input bit [2*LANES-1:0] hdr, input bit [LANES-1:0] hv);
    rst_i = rst; lane_en_i = en; rxheader_i = hdr; rxheadervalid_i = hv;
    model_step(rst, en, hdr, hv);
    for (int n = 0; n < LANES; n++) if (rst || !en[n]) last_slip[n] = -100000;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic repeat_cycle(input int reps, input bit rst, input bit [LANES-1:0] en,
                              input bit [2*LANES-1:0] hdr, input bit [LANES-1:0] hv);
    for (int i = 0; i < reps; i++) cycle(rst, en, hdr, hv);
  endtask

  typedef struct {
    string          name;
    bit             rst;
    bit [LANES-1:0] en;
    bit [7:0]       hdr;
    bit [LANES-1:0] hv;
    int             reps;
    bit [LANES-1:0] e_locked;
    bit [LANES-1:0] e_slip;
    bit             e_all;
    bit [7:0]       e_cnt0;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int off[LANES];
    bit [2*LANES-1:0] h;
    bit [LANES-1:0]   en;
    bit [LANES-1:0]   hv;
    int p_bad;

    for (int n = 0; n < LANES; n++) begin
      m_wait[n] = 0; m_good[n] = 0; m_hdrs[n] = 0; m_bads[n] = 0; m_slips[n] = 0;
      last_slip[n] = -100000;
    end

    // Reset, clean lock, 15 bad per window survives, 16th bad unlocks.
    tbl[0] = '{"reset",      1, 4'hF, 8'h55, 4'h0,  2, 4'h0, 4'h0, 0, 8'd0};
    tbl[1] = '{"good63",     0, 4'hF, 8'h55, 4'hF, 63, 4'h0, 4'h0, 0, 8'd0};
    tbl[2] = '{"good64",     0, 4'hF, 8'h55, 4'hF,  1, 4'hF, 4'h0, 0, 8'd0};
    tbl[3] = '{"all_lag",    0, 4'hF, 8'h55, 4'h0,  1, 4'hF, 4'h0, 1, 8'd0};
    tbl[4] = '{"bad15",      0, 4'hF, 8'hFF, 4'hF, 15, 4'hF, 4'h0, 1, 8'd0};
    tbl[5] = '{"win_close",  0, 4'hF, 8'h55, 4'hF, 49, 4'hF, 4'h0, 1, 8'd0};
    tbl[6] = '{"bad15_w2",   0, 4'hF, 8'h00, 4'hF, 15, 4'hF, 4'h0, 1, 8'd0};
    tbl[7] = '{"bad16",      0, 4'hF, 8'hFF, 4'hF,  1, 4'h0, 4'hF, 1, 8'd1};
    tbl[8] = '{"post_slip",  0, 4'hF, 8'h55, 4'h0,  1, 4'h0, 4'h0, 0, 8'd1};

    for (int i = 0; i < 9; i++) begin
      repeat_cycle(tbl[i].reps, tbl[i].rst, tbl[i].en, tbl[i].hdr, tbl[i].hv);
      check({"tbl_locked_", tbl[i].name}, locked_o, tbl[i].e_locked);
      check({"tbl_slip_", tbl[i].name}, rxgearboxslip_o, tbl[i].e_slip);
      check({"tbl_all_", tbl[i].name}, all_locked_o, tbl[i].e_all);
      check({"tbl_cnt0_", tbl[i].name}, slip_cnt_o[7:0], tbl[i].e_cnt0);
    end

    // 16th bad header is also the 64th header of the window: unlock wins.
    repeat_cycle(WAIT + 4, 0, 4'hF, 8'h55, 4'h0);
    repeat_cycle(LOCK, 0, 4'hF, 8'h55, 4'hF);
    check("coin_locked", locked_o, 4'hF);
    repeat_cycle(48, 0, 4'hF, 8'h55, 4'hF);
    repeat_cycle(15, 0, 4'hF, 8'hFF, 4'hF);
    check("coin_pre", locked_o, 4'hF);
    cycle(0, 4'hF, 8'hFF, 4'hF);
    check("coin_unlock", locked_o, 4'h0);
    check("coin_slip", rxgearboxslip_o, 4'hF);

    // Reset while the slip pulse is out and the lane is in SLIP_WAIT.
    cycle(1, 4'hF, 8'h55, 4'h0);
    check("rst_wait_slip", rxgearboxslip_o, 4'h0);
    check("rst_wait_cnt", slip_cnt_o, 32'h0);
    repeat_cycle(LOCK - 1, 0, 4'hF, 8'h55, 4'hF);
    check("relock63", locked_o, 4'h0);
    cycle(0, 4'hF, 8'h55, 4'hF);
    check("relock64", locked_o, 4'hF);

    // Reset while locked.
    cycle(1, 4'hF, 8'h55, 4'hF);
    check("rst_lock", {locked_o, rxgearboxslip_o, all_locked_o}, 9'h0);
    repeat_cycle(LOCK - 1, 0, 4'hF, 8'h55, 4'hF);
    check("relock2_63", locked_o, 4'h0);
    cycle(0, 4'hF, 8'h55, 4'hF);
    check("relock2_64", locked_o, 4'hF);

    // Lane 2 misaligned (aligns after two slips), lane 3 disabled.
    cycle(1, 4'hF, 8'h55, 4'h0);
    for (int i = 0; i < 200; i++) begin
      h = {2'($urandom_range(3)), (m_slips[2] >= 2) ? 2'b10 : 2'b11, 2'b01, 2'b10};
      cycle(0, 4'b0111, h, 4'hF);
      if (i == 69) begin
        check("lanes_early", locked_o, 4'b0011);
        check("all_early", all_locked_o, 1'b0);
      end
    end
    check("lanes_late", locked_o, 4'b0111);
    check("all_late", all_locked_o, 1'b1);
    check("lane2_slips", slip_cnt_o[23:16], 8'd2);
    check("lane3_cnt", slip_cnt_o[31:24], 8'd0);

    // Gearbox loopback: each slip advances the bit offset by one out of 66.
    cycle(1, 4'hF, 8'h55, 4'h0);
    off = '{37, 0, 65, 10};
    for (int i = 0; i < 3000 && locked_o != 4'hF; i++) begin
      for (int n = 0; n < LANES; n++)
        h[2*n +: 2] = (off[n] == 0) ? (($urandom_range(1) == 1) ? 2'b01 : 2'b10)
                                    : 2'($urandom_range(3));
      hv = ($urandom_range(9) == 0) ? 4'h0 : 4'hF;
      cycle(0, 4'hF, h, hv);
      for (int n = 0; n < LANES; n++) if (rxgearboxslip_o[n]) off[n] = (off[n] + 1) % 66;
    end
    check("loop_locked", locked_o, 4'hF);
    check("loop_slips", slip_cnt_o, {8'd56, 8'd1, 8'd0, 8'd29});

    // Continuous bad headers: slip count saturates at 255.
    cycle(1, 4'hF, 8'hFF, 4'h0);
    repeat_cycle(260 * (WAIT + 1), 0, 4'hF, 8'hFF, 4'hF);
    check("slip_sat", slip_cnt_o, 32'hFFFF_FFFF);

    // Randomised soak with varying header quality, resets and lane enables.
    en = 4'hF;
    for (int seg = 0; seg < 8; seg++) begin
      p_bad = (seg % 4 == 0) ? 0 : (seg % 4 == 1) ? 1 : (seg % 4 == 2) ? 20 : 50;
      for (int i = 0; i < 500; i++) begin
        for (int n = 0; n < LANES; n++) begin
          if ($urandom_range(199) == 0) en[n] = ~en[n];
          h[2*n +: 2] = ($urandom_range(99) < p_bad) ? (($urandom_range(1) == 1) ? 2'b11 : 2'b00)
                                                     : (($urandom_range(1) == 1) ? 2'b01 : 2'b10);
          hv[n] = ($urandom_range(9) < 8);
        end
        cycle(($urandom_range(299) == 0), en, h, hv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
